// File: rtl/alu_writeback.sv
// alu_writeback: latches ALU flags and sequences 8-bit register-file writes (two beats for multiply).
// Define WB_SKID_EN to add a one-entry skid buffer that removes the multiply bubble on in_ready.
module alu_writeback #(
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      nreset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                alu_operation,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
    input  logic [2:0]                alu_flags,
    input  logic [15:0]               alu_out,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [7:0]                rf_wdata,
    output logic [2:0]                status_flags,
    output logic                      busy
);
    localparam int AW = REG_ADDR_WIDTH;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    state_t state_q, state_d;
    logic cur_mul_q, cur_mul_d;
    logic [AW-1:0] cur_dest_q, cur_dest_d;
    logic [7:0] cur_hi_q, cur_hi_d;
    logic rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [7:0] rf_wdata_q, rf_wdata_d;
    logic [2:0] status_q, status_d;
    logic accept, mul_lo;
    logic nx_valid, nx_mul;
    logic [AW-1:0] nx_dest;
    logic [15:0] nx_data;

    assign mul_lo = (state_q == WR_LO) && cur_mul_q;
    assign accept = in_valid && in_ready;

`ifdef WB_SKID_EN
    logic skid_full_q, skid_full_d;
    logic skid_mul_q, skid_mul_d;
    logic [AW-1:0] skid_dest_q, skid_dest_d;
    logic [15:0] skid_data_q, skid_data_d;

    assign in_ready = !skid_full_q;

    // A result arriving during a multiply's low beat is parked; it can only drain from WR_HI.
    always_comb begin
        skid_full_d = skid_full_q;
        skid_mul_d  = skid_mul_q;
        skid_dest_d = skid_dest_q;
        skid_data_d = skid_data_q;
        if (mul_lo && accept) begin
            skid_full_d = 1'b1;
            skid_mul_d  = alu_operation == OP_MUL;
            skid_dest_d = dest_reg;
            skid_data_d = alu_out;
        end else if (state_q == WR_HI && skid_full_q) begin
            skid_full_d = 1'b0;
        end
        nx_valid = skid_full_q || (accept && !mul_lo);
        nx_mul   = skid_full_q ? skid_mul_q : alu_operation == OP_MUL;
        nx_dest  = skid_full_q ? skid_dest_q : dest_reg;
        nx_data  = skid_full_q ? skid_data_q : alu_out;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            skid_full_q <= 1'b0;
            skid_mul_q  <= 1'b0;
            skid_dest_q <= '0;
            skid_data_q <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_mul_q  <= skid_mul_d;
            skid_dest_q <= skid_dest_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    assign in_ready = !mul_lo;
    assign nx_valid = accept;
    assign nx_mul   = alu_operation == OP_MUL;
    assign nx_dest  = dest_reg;
    assign nx_data  = alu_out;
`endif

    // Outputs are registered, so they are computed from the state being entered.
    always_comb begin
        state_d    = mul_lo ? WR_HI : (nx_valid ? WR_LO : IDLE);
        cur_mul_d  = nx_valid ? nx_mul : cur_mul_q;
        cur_dest_d = nx_valid ? nx_dest : cur_dest_q;
        cur_hi_d   = nx_valid ? nx_data[15:8] : cur_hi_q;
        rf_we_d    = state_d != IDLE;
        rf_waddr_d = mul_lo ? cur_dest_q + AW'(1) : (nx_valid ? nx_dest : rf_waddr_q);
        rf_wdata_d = mul_lo ? cur_hi_q : (nx_valid ? nx_data[7:0] : rf_wdata_q);
        status_d   = accept ? alu_flags : status_q;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            cur_mul_q  <= 1'b0;
            cur_dest_q <= '0;
            cur_hi_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_mul_q  <= cur_mul_d;
            cur_dest_q <= cur_dest_d;
            cur_hi_q   <= cur_hi_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            status_q   <= status_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign status_flags = status_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed scenario tasks for alu_writeback with hand-computed expectations.
module tb_alu_writeback;
`ifdef WB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_operation = 2'b00;
    logic [2:0]  dest_reg = 3'd0;
    logic [2:0]  alu_flags = 3'd0;
    logic [15:0] alu_out = 16'h0000;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [2:0]  status_flags;
    logic        busy;
    int          pass_cnt = 0;
    int          total = 0;

    alu_writeback #(.REG_ADDR_WIDTH(3)) dut (
        .clock(clock), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_operation(alu_operation), .dest_reg(dest_reg), .alu_flags(alu_flags),
        .alu_out(alu_out), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .status_flags(status_flags), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic [1:0] op, input logic [2:0] d, input logic [15:0] v, input logic [2:0] f);
        in_valid = 1'b1;
        alu_operation = op;
        dest_reg = d;
        alu_out = v;
        alu_flags = f;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, status_flags, busy, in_ready} !== {1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b1})
            $display("FAIL reset_state: got we=%b a=%0d d=%h st=%b busy=%b rdy=%b, want 0/0/00/000/0/1",
                     rf_we, rf_waddr, rf_wdata, status_flags, busy, in_ready);
        else pass_cnt++;
        tick();
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_add();
        drive(2'b00, 3'd2, 16'h005A, 3'b010);
        tick();
        in_valid = 1'b0;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, status_flags, busy} !== {1'b1, 3'd2, 8'h5A, 3'b010, 1'b1})
            $display("FAIL add_write: got we=%b a=%0d d=%h st=%b busy=%b, want 1/2/5a/010/1",
                     rf_we, rf_waddr, rf_wdata, status_flags, busy);
        else pass_cnt++;
        tick();
        total++;
        if ({rf_we, status_flags, busy} !== {1'b0, 3'b010, 1'b0})
            $display("FAIL add_idle: got we=%b st=%b busy=%b, want 0/010/0", rf_we, status_flags, busy);
        else pass_cnt++;
    endtask

    task automatic test_mul(input logic [2:0] d, input logic [15:0] v, input logic [2:0] f,
                            input logic [2:0] hi_addr, input string nm);
        drive(2'b10, d, v, f);
        tick();
        in_valid = 1'b0;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, status_flags, in_ready} !== {1'b1, d, v[7:0], f, SKID})
            $display("FAIL %s_lo: got we=%b a=%0d d=%h st=%b rdy=%b, want 1/%0d/%h/%b/%b",
                     nm, rf_we, rf_waddr, rf_wdata, status_flags, in_ready, d, v[7:0], f, SKID);
        else pass_cnt++;
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata, status_flags, in_ready} !== {1'b1, hi_addr, v[15:8], f, 1'b1})
            $display("FAIL %s_hi: got we=%b a=%0d d=%h st=%b rdy=%b, want 1/%0d/%h/%b/1",
                     nm, rf_we, rf_waddr, rf_wdata, status_flags, in_ready, hi_addr, v[15:8], f);
        else pass_cnt++;
        tick();
        total++;
        if ({rf_we, busy} !== 2'b00)
            $display("FAIL %s_end: got we=%b busy=%b, want 0/0", nm, rf_we, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 3'(i), {8'h00, 8'(8'h11 * (i + 1))}, 3'(i + 4));
            total++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
            else pass_cnt++;
            tick();
            total++;
            if ({rf_we, rf_waddr, rf_wdata, status_flags} !== {1'b1, 3'(i), 8'(8'h11 * (i + 1)), 3'(i + 4)})
                $display("FAIL b2b_write%0d: got we=%b a=%0d d=%h st=%b, want 1/%0d/%h/%b",
                         i, rf_we, rf_waddr, rf_wdata, status_flags, i, 8'(8'h11 * (i + 1)), 3'(i + 4));
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (rf_we !== 1'b0) $display("FAIL b2b_end: got we=%b want 0", rf_we);
        else pass_cnt++;
    endtask

    task automatic test_mul_then_add();
        logic took;
        drive(2'b10, 3'd1, 16'hA0B0, 3'b001);
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd1, 8'hB0})
            $display("FAIL ma_lo: got we=%b a=%0d d=%h, want 1/1/b0", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        drive(2'b00, 3'd6, 16'h0077, 3'b110);
        total++;
        if (in_ready !== SKID) $display("FAIL ma_ready: got %b want %b", in_ready, SKID);
        else pass_cnt++;
        took = in_ready;
        tick();
        if (took) in_valid = 1'b0;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, status_flags} !== {1'b1, 3'd2, 8'hA0, SKID ? 3'b110 : 3'b001})
            $display("FAIL ma_hi: got we=%b a=%0d d=%h st=%b, want 1/2/a0/%b",
                     rf_we, rf_waddr, rf_wdata, status_flags, SKID ? 3'b110 : 3'b001);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, status_flags} !== {1'b1, 3'd6, 8'h77, 3'b110})
            $display("FAIL ma_add: got we=%b a=%0d d=%h st=%b, want 1/6/77/110",
                     rf_we, rf_waddr, rf_wdata, status_flags);
        else pass_cnt++;
        tick();
        total++;
        if (rf_we !== 1'b0) $display("FAIL ma_end: got we=%b want 0", rf_we);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive(2'b10, 3'd3, 16'hCAFE, 3'b111);
        tick();
        in_valid = 1'b0;
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd4, 8'hCA})
            $display("FAIL rm_hi: got we=%b a=%0d d=%h, want 1/4/ca", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        nreset = 1'b0;
        #1;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, status_flags, busy, in_ready} !== {1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b1})
            $display("FAIL rm_async: got we=%b a=%0d d=%h st=%b busy=%b rdy=%b, want 0/0/00/000/0/1",
                     rf_we, rf_waddr, rf_wdata, status_flags, busy, in_ready);
        else pass_cnt++;
        tick();
        nreset = 1'b1;
        tick();
        total++;
        if ({rf_we, busy, in_ready} !== 3'b001)
            $display("FAIL rm_after1: got we=%b busy=%b rdy=%b, want 0/0/1", rf_we, busy, in_ready);
        else pass_cnt++;
        tick();
        total++;
        if ({rf_we, status_flags} !== {1'b0, 3'd0})
            $display("FAIL rm_after2: got we=%b st=%b, want 0/000", rf_we, status_flags);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul(3'd4, 16'hBEEF, 3'b101, 3'd5, "mul");
        test_mul(3'd7, 16'h1234, 3'b011, 3'd0, "mulwrap");
        test_back_to_back();
        test_mul_then_add();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
